// File: rtl/editor_campos_rtc.sv
// Edit-mode controller for the RTC display: field select, BCD edits, cursor, commit handshake.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module editor_campos_rtc #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] din_dia,
    input  logic [7:0] din_mes,
    input  logic [7:0] din_year,
    input  logic [7:0] din_rh,
    input  logic [7:0] din_rm,
    input  logic [7:0] din_rs,
    input  logic [7:0] din_ch,
    input  logic [7:0] din_cm,
    input  logic [7:0] din_cs,
    output logic [7:0] dout_dia,
    output logic [7:0] dout_mes,
    output logic [7:0] dout_year,
    output logic [7:0] dout_rh,
    output logic [7:0] dout_rm,
    output logic [7:0] dout_rs,
    output logic [7:0] dout_ch,
    output logic [7:0] dout_cm,
    output logic [7:0] dout_cs,
    output logic [8:0] sig_band_cursor,
    output logic       edit_active,
    output logic       wr_req,
    input  logic       wr_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_COMMIT
    } state_t;

    if (BLINK_DIV < 1) begin : g_bad_div
        $error("BLINK_DIV must be at least 1");
    end

    state_t          state;
    logic [3:0]      idx;
    logic [3:0]      idx_nxt;
    logic [8:0][7:0] fld;
    logic [8:0][7:0] din_all;
    logic [7:0]      cur_v;
    logic [7:0]      lo_v;
    logic [7:0]      hi_v;
    logic [7:0]      edit_v;
    logic            do_up;
    logic            do_dn;
    logic            mv_r;
    logic            mv_l;
    logic            any_btn;
    logic            blink_nxt;

    assign din_all = {din_cs, din_cm, din_ch, din_rs, din_rm,
                      din_rh, din_year, din_mes, din_dia};

    assign dout_dia  = fld[0];
    assign dout_mes  = fld[1];
    assign dout_year = fld[2];
    assign dout_rh   = fld[3];
    assign dout_rm   = fld[4];
    assign dout_rs   = fld[5];
    assign dout_ch   = fld[6];
    assign dout_cm   = fld[7];
    assign dout_cs   = fld[8];

    function automatic logic [7:0] fmin(input logic [3:0] i);
        return (i <= 4'd1) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] fmax(input logic [3:0] i);
        logic [7:0] m;
        case (i)
            4'd0:    m = 8'h31;
            4'd1:    m = 8'h12;
            4'd2:    m = 8'h99;
            4'd3:    m = 8'h23;
            4'd6:    m = 8'h23;
            default: m = 8'h59;
        endcase
        return m;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (!bcd_ok(v, lo, hi) || v == hi)
            r = lo;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (!bcd_ok(v, lo, hi) || v == lo)
            r = hi;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic [8:0] onehot(input logic [3:0] i);
        return 9'h100 >> i;
    endfunction

    assign do_up   = btn_up & ~btn_down;
    assign do_dn   = btn_down & ~btn_up;
    assign mv_r    = btn_right & ~btn_left;
    assign mv_l    = btn_left & ~btn_right;
    assign any_btn = btn_edit | btn_left | btn_right | btn_up | btn_down;

    always_comb begin
        cur_v = fld[idx];
        lo_v  = fmin(idx);
        hi_v  = fmax(idx);
        edit_v = cur_v;
        if (do_up)
            edit_v = bcd_inc(cur_v, lo_v, hi_v);
        else if (do_dn)
            edit_v = bcd_dec(cur_v, lo_v, hi_v);
    end

    always_comb begin
        idx_nxt = idx;
        if (mv_r)
            idx_nxt = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        else if (mv_l)
            idx_nxt = (idx == 4'd0) ? 4'd8 : idx - 4'd1;
    end

`ifdef CURSOR_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          blink_ph;

    // Phase restarts visible on EDIT entry and any button; idle outside EDIT.
    always_comb begin
        cnt_nxt   = '0;
        blink_nxt = 1'b1;
        if (state == S_EDIT && !any_btn) begin
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_nxt = ~blink_ph;
            end else begin
                cnt_nxt   = blink_cnt + 1'b1;
                blink_nxt = blink_ph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else begin
            blink_cnt <= cnt_nxt;
            blink_ph  <= blink_nxt;
        end
    end
`else
    assign blink_nxt = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            idx             <= 4'd0;
            fld             <= '0;
            sig_band_cursor <= 9'd0;
            edit_active     <= 1'b0;
            wr_req          <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    fld             <= din_all;
                    sig_band_cursor <= 9'd0;
                    wr_req          <= 1'b0;
                    if (btn_edit) begin
                        state           <= S_EDIT;
                        idx             <= 4'd0;
                        edit_active     <= 1'b1;
                        sig_band_cursor <= onehot(4'd0) & {9{blink_nxt}};
                    end
                end
                S_EDIT: begin
                    if (btn_edit) begin
                        state           <= S_COMMIT;
                        wr_req          <= 1'b1;
                        sig_band_cursor <= onehot(idx) & {9{blink_nxt}};
                    end else begin
                        if (do_up || do_dn)
                            fld[idx] <= edit_v;
                        idx             <= idx_nxt;
                        sig_band_cursor <= onehot(idx_nxt) & {9{blink_nxt}};
                    end
                end
                S_COMMIT: begin
                    sig_band_cursor <= onehot(idx) & {9{blink_nxt}};
                    if (wr_ack) begin
                        state           <= S_IDLE;
                        wr_req          <= 1'b0;
                        edit_active     <= 1'b0;
                        sig_band_cursor <= 9'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_editor_campos_rtc.sv
// Scoreboard bench for editor_campos_rtc: directed button sequences, queued expectations.
module tb_editor_campos_rtc;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_edit, btn_left, btn_right, btn_up, btn_down, wr_ack;
    logic [7:0] din_dia, din_mes, din_year, din_rh, din_rm;
    logic [7:0] din_rs, din_ch, din_cm, din_cs;
    logic [7:0] dout_dia, dout_mes, dout_year, dout_rh, dout_rm;
    logic [7:0] dout_rs, dout_ch, dout_cm, dout_cs;
    logic [8:0] sig_band_cursor;
    logic       edit_active, wr_req;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    localparam logic [5:0] B_E = 6'b100000;
    localparam logic [5:0] B_L = 6'b010000;
    localparam logic [5:0] B_R = 6'b001000;
    localparam logic [5:0] B_U = 6'b000100;
    localparam logic [5:0] B_D = 6'b000010;
    localparam logic [5:0] B_A = 6'b000001;

    localparam int S_RH  = 3;
    localparam int S_CUR = 9;
    localparam int S_ACT = 10;
    localparam int S_REQ = 11;

    typedef struct {
        int         c;
        int         sel;
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t q[$];

    editor_campos_rtc #(.BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .btn_edit(btn_edit), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .din_dia(din_dia), .din_mes(din_mes), .din_year(din_year),
        .din_rh(din_rh), .din_rm(din_rm), .din_rs(din_rs),
        .din_ch(din_ch), .din_cm(din_cm), .din_cs(din_cs),
        .dout_dia(dout_dia), .dout_mes(dout_mes), .dout_year(dout_year),
        .dout_rh(dout_rh), .dout_rm(dout_rm), .dout_rs(dout_rs),
        .dout_ch(dout_ch), .dout_cm(dout_cm), .dout_cs(dout_cs),
        .sig_band_cursor(sig_band_cursor), .edit_active(edit_active),
        .wr_req(wr_req), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] actual(input int sel);
        case (sel)
            0:       return {1'b0, dout_dia};
            1:       return {1'b0, dout_mes};
            2:       return {1'b0, dout_year};
            3:       return {1'b0, dout_rh};
            4:       return {1'b0, dout_rm};
            5:       return {1'b0, dout_rs};
            6:       return {1'b0, dout_ch};
            7:       return {1'b0, dout_cm};
            8:       return {1'b0, dout_cs};
            9:       return sig_band_cursor;
            10:      return {8'd0, edit_active};
            11:      return {8'd0, wr_req};
            default: return 'x;
        endcase
    endfunction

    // Monitor: every cycle, pop and check all expectations due by now.
    exp_t       m_e;
    logic [8:0] m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            m_e   = q.pop_front();
            m_act = actual(m_e.sel);
            n_tests++;
            if (m_e.c != cyc || m_act !== m_e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         m_e.name, m_act, m_e.val, cyc, m_e.c);
            end
        end
    end

    task automatic expect_at(input int c, input int sel,
                             input logic [8:0] v, input string nm);
        exp_t e;
        e.c    = c;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic expect_next(input int sel, input logic [8:0] v, input string nm);
        expect_at(cyc + 1, sel, v, nm);
    endtask

    task automatic expect_now(input int sel, input logic [8:0] v, input string nm);
        expect_at(cyc, sel, v, nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [5:0] b);
        {btn_edit, btn_left, btn_right, btn_up, btn_down, wr_ack} = b;
        @(posedge clk);
        #1;
        {btn_edit, btn_left, btn_right, btn_up, btn_down, wr_ack} = 6'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {btn_edit, btn_left, btn_right, btn_up, btn_down, wr_ack} = 6'b0;
        din_dia = 8'h01; din_mes = 8'h13; din_year = 8'h24;
        din_rh  = 8'h23; din_rm  = 8'h09; din_rs   = 8'h30;
        din_ch  = 8'h01; din_cm  = 8'h02; din_cs   = 8'h03;
        tick(2);
        expect_now(S_REQ, 9'd0, "rst_wr_req");
        expect_now(S_RH, 9'h00, "rst_rh");
        expect_now(S_CUR, 9'd0, "rst_cursor");

        reset = 1'b0;
        expect_next(S_RH, 9'h23, "idle_track_rh");
        expect_next(S_CUR, 9'd0, "idle_cursor");
        expect_next(S_REQ, 9'd0, "idle_wr_req");
        expect_next(S_ACT, 9'd0, "idle_edit_active");
        tick(1);

        expect_next(S_ACT, 9'd1, "enter_edit_active");
        expect_next(S_CUR, 9'h100, "enter_cursor_idx0");
        pulse(B_E);
        din_rh = 8'h11;

        expect_next(S_CUR, 9'h080, "right_idx1");
        pulse(B_R);
        expect_next(S_CUR, 9'h040, "right_idx2");
        pulse(B_R);
        expect_next(S_CUR, 9'h020, "right_idx3");
        pulse(B_R);
        expect_next(S_RH, 9'h00, "rh_up_wrap");
        expect_next(S_CUR, 9'h020, "rh_cursor");
        pulse(B_U);
        tick(2);
        expect_now(S_RH, 9'h00, "rh_frozen");

        expect_next(S_CUR, 9'h010, "right_idx4");
        pulse(B_R);
        expect_next(4, 9'h10, "rm_up_carry");
        pulse(B_U);

        expect_next(S_CUR, 9'h020, "left_idx3");
        pulse(B_L);
        expect_next(S_CUR, 9'h040, "left_idx2");
        pulse(B_L);
        expect_next(S_CUR, 9'h080, "left_idx1");
        pulse(B_L);
        expect_next(S_CUR, 9'h100, "left_idx0");
        pulse(B_L);

        expect_next(0, 9'h31, "dia_down_wrap");
        pulse(B_D);
        expect_next(0, 9'h01, "dia_up_wrap");
        pulse(B_U);

        expect_next(S_CUR, 9'h001, "left_wrap_idx8");
        pulse(B_L);
        expect_next(8, 9'h03, "up_down_nochange");
        expect_next(S_CUR, 9'h001, "up_down_cursor");
        pulse(B_U | B_D);
        expect_next(8, 9'h04, "up_left_edit");
        expect_next(S_CUR, 9'h002, "up_left_move");
        pulse(B_U | B_L);

        expect_next(S_CUR, 9'h001, "right_idx8");
        pulse(B_R);
        expect_next(S_CUR, 9'h100, "right_wrap_idx0");
        pulse(B_R);
        expect_next(S_CUR, 9'h080, "right_idx1b");
        pulse(B_R);
        expect_next(S_CUR, 9'h080, "left_right_nomove");
        pulse(B_L | B_R);
        expect_next(1, 9'h12, "mes_invalid_down");
        pulse(B_D);

        expect_next(S_REQ, 9'd1, "commit_wr_req");
        expect_next(1, 9'h12, "commit_no_edit");
        expect_next(S_ACT, 9'd1, "commit_edit_active");
        pulse(B_E | B_U);
        din_rh = 8'h05;

        for (int i = 0; i < 10; i++) begin
            expect_next(S_REQ, 9'd1, "commit_hold_req");
            expect_next(1, 9'h12, "commit_hold_mes");
            pulse((i % 2 == 0) ? (B_E | B_U | B_R) : (B_D | B_L));
        end

        expect_next(S_REQ, 9'd0, "ack_req_low");
        expect_next(S_ACT, 9'd0, "ack_edit_inactive");
        expect_next(S_CUR, 9'd0, "ack_cursor_off");
        expect_next(S_RH, 9'h00, "ack_rh_hold");
        pulse(B_A);
        expect_next(S_RH, 9'h05, "resume_rh");
        expect_next(1, 9'h13, "resume_mes");
        tick(1);

        expect_next(S_REQ, 9'd0, "idle_ack_ignored");
        expect_next(S_ACT, 9'd0, "idle_ack_no_edit");
        pulse(B_A);

        pulse(B_E);
        pulse(B_E);
        expect_now(S_REQ, 9'd1, "commit2_wr_req");
        tick(1);
        reset = 1'b1;
        for (int s = 0; s < 9; s++) expect_next(s, 9'h00, "rst_commit_dout");
        expect_next(S_REQ, 9'd0, "rst_commit_req");
        expect_next(S_ACT, 9'd0, "rst_commit_act");
        tick(1);
        reset = 1'b0;
        expect_next(S_RH, 9'h05, "post_rst_track");
        tick(1);

`ifdef CURSOR_BLINK_EN
        pulse(B_E);
        for (int k = 0; k < 6; k++)
            expect_at(cyc + k, S_CUR, (k < 4) ? 9'h100 : 9'h000, "blink_phase");
        tick(5);
        for (int k = 1; k < 6; k++)
            expect_at(cyc + k, S_CUR, (k < 5) ? 9'h080 : 9'h000, "blink_restart");
        pulse(B_R);
        tick(5);
        pulse(B_E);
        pulse(B_A);
        tick(1);
`endif

        for (int t = 0; t < 20 && q.size() > 0; t++) tick(1);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/editor_campos_rtc.md
# editor_campos_rtc

Edit-mode controller for the RTC display datapath. Tracks which of the nine BCD fields (date, clock, timer) is selected. Applies up/down edits with per-field wrap limits and drives the 9-bit cursor mask consumed by the text generator. On exit it hands the edited set to the RTC write interface through a req/ack handshake.

## Interface
Parameters:
- BLINK_DIV, 25_000_000: clock cycles per cursor blink half-period. Used only with CURSOR_BLINK_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_edit  in  1  one-cycle pulse, debounced upstream; enters edit mode or commits.
- btn_left, btn_right  in  1 each  one-cycle pulses; move the cursor.
- btn_up, btn_down  in  1 each  one-cycle pulses; change the selected field.
- din_dia, din_mes, din_year, din_rh, din_rm, din_rs, din_ch, din_cm, din_cs  in  8 each  live packed-BCD values from the RTC reader.
- dout_dia, dout_mes, dout_year, dout_rh, dout_rm, dout_rs, dout_ch, dout_cm, dout_cs  out  8 each  registered BCD values to the display and the RTC writer.
- sig_band_cursor  out  9  one-hot cursor mask; field idx maps to bit 8−idx.
- edit_active  out  1  high in EDIT and COMMIT.
- wr_req  out  1  commit request, held until acknowledged.
- wr_ack  in  1  one-cycle acknowledge from the RTC writer.

## Operation
Field index and limits (idx: field, range):
- 0: dia, 01–31
- 1: mes, 01–12
- 2: year, 00–99
- 3: rh, 00–23
- 4: rm, 00–59
- 5: rs, 00–59
- 6: ch, 00–23
- 7: cm, 00–59
- 8: cs, 00–59

State machine:
- IDLE
  - Every cycle: dout_* <= din_*.
  - sig_band_cursor = 0, edit_active = 0, wr_req = 0.
  - btn_edit → EDIT. dout_* freeze at the value loaded that cycle; idx = 0.
- EDIT
  - dout_* hold except for edits; din_* are ignored.
  - btn_right: idx+1, with 8 wrapping to 0.
  - btn_left: idx−1, with 0 wrapping to 8.
  - btn_up: selected field +1 in BCD (digit carry, e.g. 0x19 → 0x20). Max wraps to min.
  - btn_down: selected field −1 in BCD. Min wraps to max.
  - Out-of-range or non-BCD field value: up → min, down → max.
  - btn_edit → COMMIT.
- COMMIT
  - wr_req = 1; dout_* stable; all buttons ignored.
  - When wr_ack is sampled high → IDLE.

Simultaneous events:
- btn_edit asserted with any other button: btn_edit wins, the others are ignored.
- up and down together: no change.
- left and right together: no move.
- up/down together with left/right: the edit applies to the current idx, then the cursor moves.
- wr_ack outside COMMIT: ignored.

Reset (any state, including mid-COMMIT):
- State → IDLE, idx = 0.
- wr_req = 0, edit_active = 0, sig_band_cursor = 0, all dout_* = 8'h00.
- dout_* reload from din_* on the first cycle after reset is released.

## Timing
- All outputs are registered.
- A button pulse sampled at edge n takes effect at edge n: the new dout/idx/cursor is visible in the following cycle.
- IDLE tracking latency is 1 cycle from din_* to dout_*.
- btn_edit in EDIT at edge n: wr_req and dout_* are stable from cycle n+1.
- wr_ack sampled at edge m: wr_req is low and the state is IDLE from cycle m+1; tracking of din_* resumes at edge m+1.
- In EDIT, sig_band_cursor[8−idx] = 1 and all other bits are 0. The mask updates in the same cycle as idx.

## Configuration
CURSOR_BLINK_EN:
- Defined:
  - A counter toggles a blink phase every BLINK_DIV cycles.
  - The counter resets, with the phase set to visible, on entry to EDIT and on any button pulse.
  - sig_band_cursor equals the one-hot mask ANDed with the phase.
  - The counter is held in reset outside EDIT.
- Undefined: no counter; the one-hot mask is steady during EDIT.

## Test plan
- Reset, din_rh = 0x23: one cycle after reset is released, dout_rh = 0x23, sig_band_cursor = 0, wr_req = 0.
- btn_edit, then btn_right ×3 and btn_up with dout_rh = 0x23: dout_rh = 0x00 and sig_band_cursor = 9'b000100000. A later change of din_rh does not alter dout_rh.
- idx = 0 with dout_dia = 0x01: btn_down gives 0x31, btn_up gives 0x01. With dout_rm = 0x09, btn_up gives 0x10.
- idx = 0: btn_left gives idx 8 (cursor 9'b000000001). Up and down in the same cycle leave the field unchanged. btn_edit together with btn_up commits without an edit.
- COMMIT with wr_ack withheld for 10 cycles: wr_req stays high and buttons are ignored. On wr_ack, wr_req drops the next cycle and IDLE tracking resumes. A repeat run with reset mid-COMMIT gives wr_req = 0 and all dout = 0x00 the next cycle.
- CURSOR_BLINK_EN defined, BLINK_DIV = 4, in EDIT: the cursor bit toggles every 4 cycles. A btn_right pulse restarts the phase as visible.
